// File: rtl/multiplicador_seq.sv
// Sequential shift-add unsigned multiplier (A/Q/M registers, N add/shift steps).
// Define RESTO_EN to add the `resto` port, which is preloaded into A and so added to the product.
module multiplicador_seq #(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N-1:0]             multiplicando,
    input  logic [N-1:0]             multiplicador,
`ifdef RESTO_EN
    input  logic [N-1:0]             resto,
`endif
    output logic [2*N-1:0]           produto,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N+1)-1:0]   count,
    output logic [1:0]               state_dbg
);

    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N:0]      a_q;
    logic [N-1:0]    q_q;
    logic [N-1:0]    m_q;
    logic [CW-1:0]   count_q;

    logic [N:0]      sum_d;
    logic [2*N:0]    shift_d;

    // One step: conditionally add M into A (carry lands in A[N]), then shift {A,Q} right.
    always_comb begin
        sum_d   = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
        shift_d = {sum_d, q_q} >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef RESTO_EN
                        a_q <= {1'b0, resto};
`else
                        a_q <= '0;
`endif
                        q_q     <= multiplicador;
                        m_q     <= multiplicando;
                        count_q <= CW'(N);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q     <= shift_d[2*N:N];
                    q_q     <= shift_d[N-1:0];
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // After N shifts the carry bit A[N] is always zero, so the product fits in {A[N-1:0], Q}.
    assign produto   = {a_q[N-1:0], q_q};
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign count     = count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Bench for multiplicador_seq (N = 4): directed scenarios plus random traffic against a cycle model.
module tb_multiplicador_seq;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N-1:0]    multiplicando;
  logic [N-1:0]    multiplicador;
  logic [N-1:0]    resto;
  logic [2*N-1:0]  produto;
  logic            busy;
  logic            done;
  logic [CW-1:0]   count;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // ---------------- clock / dut ----------------
  always #5 clk = ~clk;

  multiplicador_seq #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
`ifdef RESTO_EN
    .resto         (resto),
`endif
    .produto       (produto),
    .busy          (busy),
    .done          (done),
    .count         (count),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = idle, 1 = working, 2 = result cycle; steps counts edges spent working.
  int              m_phase = 0;
  int              m_steps = 0;
  logic [2*N-1:0]  m_pending = '0;
  logic [2*N-1:0]  m_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_steps = 0;
      m_prod  = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_pending = (2*N)'(multiplicando) * (2*N)'(multiplicador);
`ifdef RESTO_EN
          m_pending = m_pending + (2*N)'(resto);
`endif
          m_phase = 1;
          m_steps = 0;
        end
        1: begin
          m_steps++;
          if (m_steps == N) begin
            m_phase = 2;
            m_prod  = m_pending;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done", 32'(done), 32'(m_phase == 2));
      check("count", 32'(count), (m_phase == 1) ? 32'(N - m_steps) : 32'd0);
      if (m_phase != 1) check("produto", 32'(produto), 32'(m_prod));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int cycles, output bit seen);
    seen = 0;
    cycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  // Pulses start for one cycle, then waits for done; cycles is counted from the load edge.
  task automatic run_op(input string name, input int a, input int b, input int r,
                        input int exp_prod);
    int  cyc;
    bit  seen;
    @(negedge clk);
    multiplicando = N'(a);
    multiplicador = N'(b);
    resto         = N'(r);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, seen);
    if (seen) begin
      check({name, "_latency"}, 32'(cyc + 1), 32'(N + 1));
      check({name, "_produto"}, 32'(produto), 32'(exp_prod));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  cyc;
    int  t1;
    bit  seen;
    bit  saw_done;

    rst = 1'b1;
    start = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    resto = '0;
    repeat (2) @(negedge clk);
    check("rst_produto", 32'(produto), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // basic, count trace 4..0
    @(negedge clk);
    multiplicando = 4'd13;
    multiplicador = 4'd11;
    resto = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("basic_count", 32'(count), 32'(N - k));
      @(negedge clk);
    end
    check("basic_done", 32'(done), 32'd1);
    check("basic_count_end", 32'(count), 32'd0);
    check("basic_produto", 32'(produto), 32'd143);

    run_op("zero", 0, 15, 0, 0);
    run_op("max", 15, 15, 0, 225);
`ifdef RESTO_EN
    run_op("resto_max", 15, 15, 15, 240);
    run_op("resto_div", 2, 3, 1, 7);
`endif

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    multiplicando = 4'd5;
    multiplicador = 4'd6;
    resto = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    multiplicando = 4'd1;
    multiplicador = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, seen);
    if (seen) check("ignore_produto", 32'(produto), 32'd30);
    repeat (4) @(negedge clk);
    check("hold_produto", 32'(produto), 32'd30);

    // reset during step 2 of 9x9
    @(negedge clk);
    multiplicando = 4'd9;
    multiplicador = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_produto", 32'(produto), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op("after_abort", 9, 9, 0, 81);

    // back-to-back with start held high
    @(negedge clk);
    multiplicando = 4'd3;
    multiplicador = 4'd5;
    start = 1'b1;
    @(negedge clk);
    multiplicando = 4'd6;
    multiplicador = 4'd7;
    wait_done(cyc, seen);
    t1 = cyc;
    if (seen) check("b2b_first", 32'(produto), 32'd15);
    wait_done(cyc, seen);
    start = 1'b0;
    if (seen) begin
      check("b2b_second", 32'(produto), 32'd42);
      check("b2b_spacing", 32'(cyc), 32'(N + 2));
    end
    repeat (3) @(negedge clk);

    // random traffic checked cycle by cycle by the compare process
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start         = ($urandom_range(0, 3) == 0);
      rst           = ($urandom_range(0, 49) == 0);
      multiplicando = N'($urandom_range(0, 15));
      multiplicador = N'($urandom_range(0, 15));
      resto         = N'($urandom_range(0, 15));
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplicador_seq.md
# multiplicador_seq

Sequential shift-add unsigned multiplier: the inverse operation of the team's restoring divider. Computes `multiplicando × multiplicador` (optionally `+ resto`) over N add/shift cycles using an A/Q/M register set, a bit counter and an internal control FSM with a start/done handshake. It reconstructs dividends from quotient/divisor/remainder, for example as a self-check alongside the divider.

## Interface
- `N`, default 4: operand width in bits; N ≥ 2.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a multiplication; sampled only in IDLE.
- `multiplicando`, input, N: operand loaded into register M.
- `multiplicador`, input, N: operand loaded into register Q.
- `resto`, input, N: addend preloaded into A; present only with `RESTO_EN`.
- `produto`, output, 2N: result `{A[N-1:0], Q}`.
- `busy`, output, 1: high in CALC and DONE.
- `done`, output, 1: one-cycle pulse; `produto` is valid while it is high.
- `count`, output, `$clog2(N+1)`: remaining add/shift steps.

## Operation
- Registers:
  - A: N+1 bits, MSB is the carry.
  - Q: N bits.
  - M: N bits.
  - count: `$clog2(N+1)` bits.
  - state: 2 bits.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - If `start` is high: A ← 0 (or `{1'b0, resto}`), Q ← `multiplicador`, M ← `multiplicando`, count ← N, next state CALC.
  - If `start` is low: hold every register; `produto` keeps its last result.
- CALC, one step per cycle:
  - S = Q[0] ? A + {1'b0, M} : A, computed N+1 bits wide.
  - {A, Q} ← {S, Q} >> 1, zero-filled.
  - count ← count − 1.
  - When count = 1 before the edge, next state is DONE.
- DONE: `done` = 1 for this cycle; next state IDLE unconditionally.
- Width rule: A + M never exceeds 2^(N+1) − 2, and A < 2^N after every shift, so no overflow is possible. This holds with `resto` too: (2^N−1)² + (2^N−1) < 2^2N.
- `start` is ignored in CALC and DONE. There is no queueing; a new request needs `start` high in IDLE.
- Operand inputs are sampled only on the load edge. Changes during CALC have no effect.
- Zero operands take the full N steps; there is no early exit.

## Timing
- Reset values: state = IDLE, A = 0, Q = 0, M = 0, count = 0. Therefore `produto` = 0, `busy` = 0, `done` = 0.
- `rst` has priority over every other input, including `start` in the same cycle.
- `rst` during CALC or DONE aborts: all registers are zero and state is IDLE after that edge, and no `done` pulse follows.
- Latency, with `start` sampled high at edge 0 in IDLE:
  - Load at edge 0.
  - Steps at edges 1..N.
  - `done` = 1 and `produto` valid in the cycle after edge N.
  - IDLE after edge N+1.
- Throughput: one result per N+2 cycles. `start` held high continuously yields back-to-back operations, each reloaded at the IDLE edge.
- `busy` rises the cycle after the load edge and falls the cycle after `done`.
- `done` and `busy` are Moore outputs decoded from the state register.

## Configuration
- Macro name: `RESTO_EN`.
- Defined: the `resto` port exists, A preloads `{1'b0, resto}`, and the result is `produto = multiplicando × multiplicador + resto`.
- Undefined: the `resto` port is absent, A preloads 0, and the result is `produto = multiplicando × multiplicador`.
- Timing and FSM are identical either way.

## Test plan
All scenarios use N = 4.
- Basic multiply: `multiplicando` = 13, `multiplicador` = 11, `start` pulsed → `done` 5 cycles after the load edge, `produto` = 143 (8'h8F), `count` 4→0.
- Zero and maximum operands: 0×15 → 0. Then 15×15 → 225. Each `done` arrives after exactly N+1 cycles.
- With `RESTO_EN` defined: 15×15 + `resto` 15 → 240. Then 2×3 + 1 → 7, matching divider inputs `dividendo` = 7, `divisor` = 2.
- Start ignored while busy: `start` re-pulsed during CALC with 1×1 → the first result completes unchanged. `produto` holds in IDLE until the next accepted `start`.
- Reset mid-operation: `rst` asserted at step 2 of 9×9 → next cycle `produto` = 0, `busy` = 0, `count` = 0, and no `done` pulse. A fresh 9×9 then returns 81.
- Back-to-back: `start` held high for 3×5 then 6×7 → two `done` pulses N+2 cycles apart, with results 15 then 42.
